encoder83_arb: RTL and testbench

- Registered 8-to-3 priority encoder with request latching and a valid/ready output handshake.
- Collects up to eight event lines into a sticky pending register and presents one encoded 3-bit code at a time, highest priority first.
- The consumer acknowledges each code; the acknowledgement clears only the corresponding pending bit.
- Sits in front of any block that consumes the team's 3-bit event code, performing the inverse of the 3-8 decode mapping.

---
 rtl/enc83_pkg.sv | 38 +++
 rtl/encoder83_arb_prio_pick8.sv | 47 ++++
 rtl/encoder83_arb.sv | 107 ++++++++++
 tb/tb_encoder83_arb.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc83_pkg.sv
// Shared types and code mapping for the 8-to-3 event encoder.
// Optional rotating priority: ENC83_ROUND_ROBIN_EN.
package enc83_pkg;

  typedef logic [7:0] req_vec_t;
  typedef logic [2:0] code_t;

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

  localparam code_t CODE_B0 = 3'b001;
  localparam code_t CODE_B1 = 3'b010;
  localparam code_t CODE_B2 = 3'b011;
  localparam code_t CODE_B3 = 3'b100;
  localparam code_t CODE_B4 = 3'b101;
  localparam code_t CODE_B5 = 3'b110;
  localparam code_t CODE_B6 = 3'b111;
  localparam code_t CODE_B7 = 3'b000;

  // Inverse of the 3-8 decode: bit i carries code (i+1) mod 8
  function automatic code_t idx_to_code(input logic [2:0] i);
    code_t c;
    unique case (i)
      3'd0: c = CODE_B0;
      3'd1: c = CODE_B1;
      3'd2: c = CODE_B2;
      3'd3: c = CODE_B3;
      3'd4: c = CODE_B4;
      3'd5: c = CODE_B5;
      3'd6: c = CODE_B6;
      default: c = CODE_B7;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/encoder83_arb_prio_pick8.sv
// Combinational 8-way picker: highest index first, or an upward
// wrapping search from start when ENC83_ROUND_ROBIN_EN is defined.
module prio_pick8
  import enc83_pkg::*;
(
  input  req_vec_t   elig,
  input  logic [2:0] start,
  output logic       found,
  output logic [2:0] idx,
  output req_vec_t   onehot
);

`ifdef ENC83_ROUND_ROBIN_EN
  logic [2:0] j;

  // Walk backwards so the last hit is the first in search order
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = 7; k >= 0; k--) begin
      j = start + k[2:0];
      if (elig[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
    onehot = found ? (8'h01 << idx) : 8'h00;
  end
`else
  logic unused_start;
  assign unused_start = ^start;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < 8; k++) begin
      if (elig[k]) begin
        found = 1'b1;
        idx   = 3'(k);
      end
    end
    onehot = found ? (8'h01 << idx) : 8'h00;
  end
`endif

endmodule

// File: rtl/encoder83_arb.sv
// Registered 8-to-3 priority encoder with sticky pending requests.
// ENC83_ROUND_ROBIN_EN enables a rotating last-grant pointer.
module encoder83_arb
  import enc83_pkg::*;
#(
  parameter req_vec_t PEND_RESET = 8'h00
) (
  input  logic     clk,
  input  logic     rst_n,
  input  req_vec_t req,
  input  req_vec_t req_mask,
  output logic     out_valid,
  input  logic     out_ready,
  output code_t    out_code,
  output req_vec_t out_onehot,
  output req_vec_t pending
);

  state_t     state, state_n;
  logic       valid_n;
  code_t      code_n;
  req_vec_t   onehot_n;
  logic       fire;
  req_vec_t   clr;
  req_vec_t   elig;
  logic [2:0] start;
  logic       found;
  logic [2:0] win_idx;
  req_vec_t   win_oh;

  assign fire = out_valid & out_ready;
  assign clr  = fire ? out_onehot : 8'h00;
  // Registered pending only: a same-cycle req never competes here
  assign elig = pending & ~clr & req_mask;

`ifdef ENC83_ROUND_ROBIN_EN
  logic [2:0] last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 3'd7;
    end else if (fire) begin
      last <= out_code - 3'd1;
    end
  end

  // Code of the granted bit equals its index + 1
  assign start = fire ? out_code : last + 3'd1;
`else
  assign start = 3'd0;
`endif

  prio_pick8 u_pick (
    .elig   (elig),
    .start  (start),
    .found  (found),
    .idx    (win_idx),
    .onehot (win_oh)
  );

  always_comb begin
    state_n  = state;
    valid_n  = out_valid;
    code_n   = out_code;
    onehot_n = out_onehot;
    unique case (state)
      IDLE: begin
        if (found) begin
          valid_n  = 1'b1;
          code_n   = idx_to_code(win_idx);
          onehot_n = win_oh;
          state_n  = OFFER;
        end
      end
      OFFER: begin
        if (fire) begin
          if (found) begin
            code_n   = idx_to_code(win_idx);
            onehot_n = win_oh;
          end else begin
            valid_n  = 1'b0;
            onehot_n = 8'h00;
            state_n  = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= PEND_RESET;
      out_valid  <= 1'b0;
      out_code   <= 3'b000;
      out_onehot <= 8'h00;
    end else begin
      state      <= state_n;
      pending    <= (pending & ~clr) | req;
      out_valid  <= valid_n;
      out_code   <= code_n;
      out_onehot <= onehot_n;
    end
  end

endmodule

// File: tb/tb_encoder83_arb.sv
// Scenario bench for encoder83_arb with an expected-code queue.
// Inputs change and outputs are sampled on the falling edge.
module tb_encoder83_arb;
  import enc83_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n = 1'b0;
  req_vec_t req = 8'h00;
  req_vec_t req_mask = 8'hFF;
  logic     out_ready = 1'b0;
  logic     out_valid;
  code_t    out_code;
  req_vec_t out_onehot;
  req_vec_t pending;

  int    n_cmp = 0;
  int    n_bad = 0;
  code_t expq[$];
  code_t e;

  always #5 clk = ~clk;

  encoder83_arb #(.PEND_RESET(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_mask   (req_mask),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .out_onehot (out_onehot),
    .pending    (pending)
  );

  function automatic req_vec_t exp_oh(input code_t c);
    req_vec_t v;
    code_t    s;
    v = 8'h01;
    s = c - 3'd1;
    return v << s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 8'h00;
    req_mask = 8'hFF;
    out_ready = 1'b0;
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_valid got=%b want=0", out_valid);
    end
    n_cmp++;
    if (out_code !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_code got=%b want=000", out_code);
    end
    n_cmp++;
    if (out_onehot !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_onehot got=%h want=00", out_onehot);
    end
    n_cmp++;
    if (pending !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_pending got=%h want=00", pending);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    do_reset();
    expq.push_back(3'b001);
    req = 8'h01;
    out_ready = 1'b1;
    @(negedge clk);
    req = 8'h00;
    n_cmp++;
    if (out_valid !== 1'b0 || pending !== 8'h01) begin
      n_bad++;
      $display("FAIL single_latency valid=%b pend=%h want 0/01",
               out_valid, pending);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL single_valid got=%b want=1", out_valid);
    end else begin
      e = expq.pop_front();
      n_cmp++;
      if (out_code !== e || out_onehot !== exp_oh(e)) begin
        n_bad++;
        $display("FAIL single_code got=%b/%h want=%b/%h",
                 out_code, out_onehot, e, exp_oh(e));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || pending !== 8'h00) begin
      n_bad++;
      $display("FAIL single_after valid=%b pend=%h want 0/00",
               out_valid, pending);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    expq.push_back(3'b000);
    expq.push_back(3'b001);
    req = 8'h81;
    out_ready = 1'b1;
    @(negedge clk);
    req = 8'h00;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b_valid[%0d] got=%b want=1", i, out_valid);
      end else begin
        e = expq.pop_front();
        n_cmp++;
        if (out_code !== e || out_onehot !== exp_oh(e)) begin
          n_bad++;
          $display("FAIL b2b_code[%0d] got=%b/%h want=%b/%h",
                   i, out_code, out_onehot, e, exp_oh(e));
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_end got=%b want=0", out_valid);
    end
  endtask

  task automatic test_hold();
    do_reset();
    expq.push_back(3'b011);
    expq.push_back(3'b000);
    req = 8'h04;
    @(negedge clk);
    req = 8'h00;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      req = (i == 0) ? 8'h80 : 8'h00;
      req_mask = (i == 1) ? 8'h00 : 8'hFF;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_code !== 3'b011 ||
          out_onehot !== 8'h04) begin
        n_bad++;
        $display("FAIL hold[%0d] got=%b/%b/%h want=1/011/04",
                 i, out_valid, out_code, out_onehot);
      end
    end
    n_cmp++;
    if (pending !== 8'h84) begin
      n_bad++;
      $display("FAIL hold_pending got=%h want=84", pending);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL hold_acc_valid[%0d] got=%b want=1", i, out_valid);
      end else begin
        e = expq.pop_front();
        n_cmp++;
        if (out_code !== e || out_onehot !== exp_oh(e)) begin
          n_bad++;
          $display("FAIL hold_acc_code[%0d] got=%b/%h want=%b/%h",
                   i, out_code, out_onehot, e, exp_oh(e));
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || pending !== 8'h00) begin
      n_bad++;
      $display("FAIL hold_end valid=%b pend=%h want 0/00",
               out_valid, pending);
    end
  endtask

  task automatic test_mask();
    do_reset();
    req_mask = 8'hFE;
    req = 8'h01;
    out_ready = 1'b1;
    @(negedge clk);
    req = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || pending !== 8'h01) begin
        n_bad++;
        $display("FAIL mask_block[%0d] valid=%b pend=%h want 0/01",
                 i, out_valid, pending);
      end
    end
    expq.push_back(3'b001);
    req_mask = 8'hFF;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL mask_open_valid got=%b want=1", out_valid);
    end else begin
      e = expq.pop_front();
      n_cmp++;
      if (out_code !== e || out_onehot !== exp_oh(e)) begin
        n_bad++;
        $display("FAIL mask_open_code got=%b/%h want=%b/%h",
                 out_code, out_onehot, e, exp_oh(e));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || pending !== 8'h00) begin
      n_bad++;
      $display("FAIL mask_end valid=%b pend=%h want 0/00",
               out_valid, pending);
    end
  endtask

  task automatic test_set_wins();
    do_reset();
    expq.push_back(3'b100);
    expq.push_back(3'b100);
    req = 8'h08;
    @(negedge clk);
    req = 8'h00;
    @(negedge clk);
    req = 8'h08;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) begin
        @(negedge clk);
        req = 8'h00;
        n_cmp++;
        if (out_valid !== 1'b0 || pending !== 8'h08) begin
          n_bad++;
          $display("FAIL setwin_kept valid=%b pend=%h want 0/08",
                   out_valid, pending);
        end
        @(negedge clk);
      end
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL setwin_valid[%0d] got=%b want=1", i, out_valid);
      end else begin
        e = expq.pop_front();
        n_cmp++;
        if (out_code !== e || out_onehot !== exp_oh(e)) begin
          n_bad++;
          $display("FAIL setwin_code[%0d] got=%b/%h want=%b/%h",
                   i, out_code, out_onehot, e, exp_oh(e));
        end
      end
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || pending !== 8'h00) begin
      n_bad++;
      $display("FAIL setwin_end valid=%b pend=%h want 0/00",
               out_valid, pending);
    end
  endtask

  task automatic test_priority_order();
    do_reset();
    for (int i = 0; i < 9; i++) begin
`ifdef ENC83_ROUND_ROBIN_EN
      expq.push_back(3'((i + 1) % 8));
`else
      // The just-granted bit sits out one selection, so bit6 interleaves
      expq.push_back((i % 2 == 0) ? 3'b000 : 3'b111);
`endif
    end
    req = 8'hFF;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL order_latency got=%b want=0", out_valid);
    end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL order_valid[%0d] got=%b want=1", i, out_valid);
      end else begin
        e = expq.pop_front();
        n_cmp++;
        if (out_code !== e || out_onehot !== exp_oh(e)) begin
          n_bad++;
          $display("FAIL order_code[%0d] got=%b/%h want=%b/%h",
                   i, out_code, out_onehot, e, exp_oh(e));
        end
      end
    end
    req = 8'h00;
  endtask

  task automatic test_reset_mid_offer();
    do_reset();
    req = 8'h10;
    @(negedge clk);
    req = 8'h00;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || out_code !== 3'b101) begin
      n_bad++;
      $display("FAIL midrst_pre got=%b/%b want=1/101", out_valid, out_code);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_onehot !== 8'h00 ||
        pending !== 8'h00) begin
      n_bad++;
      $display("FAIL midrst got=%b/%h/%h want=0/00/00",
               out_valid, out_onehot, pending);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_mask();
    test_set_wins();
    test_priority_order();
    test_reset_mid_offer();
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL queue_left got=%0d want=0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
